// File: rtl/mnist_pkg.sv
// Shared constants and the frame-loader state encoding for the MNIST
// inference path (UART feeder, image buffer, inference controller).
package mnist_pkg;

   localparam int         N_PIX       = 784;
   localparam int         ADDR_W      = 10;
   localparam int         PIX_W       = 8;
   localparam logic [7:0] HDR_BYTE    = 8'hA5;
   localparam int         TIMEOUT_CYC = 1000000;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RECV      = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      RELEASE   = 3'd4
   } ldr_state_t;

endpackage

// File: rtl/img_frame_loader_byte_timeout_cnt.sv
// Inter-byte watchdog: loadable down-counter, reloaded on every accepted
// byte, decremented on idle cycles, pulses expire when it runs out.
//   clk, rst_n : clock, async active-low reset (counter reloads)
//   load       : reload to LOAD_VAL (byte accepted / not receiving)
//   en         : idle receive cycle, count down
//   expire     : combinational, idle cycle seen with counter at zero
module byte_timeout_cnt #(
   parameter int          CNT_W    = 20,
   parameter int unsigned LOAD_VAL = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_VAL);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= LOAD_V;
      end else if (load) begin
         cnt <= LOAD_V;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // LOAD_VAL idle cycles drain the counter; the next idle cycle expires.
   assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/img_frame_loader.sv
// Frame loader: header-framed pixel stream into the image buffer, then
// start/done handshake with the inference controller.
//   rx_data/rx_valid/rx_ready : byte stream from the UART receiver
//   img_we/img_addr/img_wdata : registered image buffer write port
//   start/fsm_busy/fsm_done/pred_in : inference controller handshake
//   result_valid/result_digit : latched prediction, one-cycle update pulse
//   frame_err : one-cycle pulse on inter-byte timeout; loading : in RECV
module img_frame_loader #(
   parameter int         N_PIX       = mnist_pkg::N_PIX,
   parameter int         ADDR_W      = mnist_pkg::ADDR_W,
   parameter int         PIX_W       = mnist_pkg::PIX_W,
   parameter logic [7:0] HDR_BYTE    = mnist_pkg::HDR_BYTE,
   parameter int         TIMEOUT_CYC = mnist_pkg::TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PIX_W-1:0]  rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              img_we,
   output logic [ADDR_W-1:0] img_addr,
   output logic [PIX_W-1:0]  img_wdata,
   output logic              start,
   input  logic              fsm_busy,
   input  logic              fsm_done,
   input  logic [3:0]        pred_in,
   output logic              result_valid,
   output logic [3:0]        result_digit,
   output logic              frame_err,
   output logic              loading
);

   import mnist_pkg::*;

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   ldr_state_t        state_q;
   ldr_state_t        state_d;
   logic [ADDR_W-1:0] pix_cnt;
   logic              in_recv;
   logic              accept;
   logic              last_pix;
   logic              is_hdr;
   logic              to_expire;

   assign in_recv  = (state_q == RECV);
   // Gated by rst_n so the port reads 0 while reset is held.
   assign rx_ready = rst_n &&
                     ((state_q == IDLE) || (state_q == RECV));
   assign accept   = rx_valid && rx_ready;
   assign loading  = in_recv;
   assign last_pix = (pix_cnt == ADDR_W'(N_PIX - 1));
   assign is_hdr   = (rx_data == PIX_W'(HDR_BYTE));

   byte_timeout_cnt #(
      .CNT_W    (TO_W),
      .LOAD_VAL (TIMEOUT_CYC - 1)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (!in_recv || accept),
      .en     (in_recv && !accept),
      .expire (to_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept && is_hdr) state_d = RECV;
         end
         RECV: begin
            // Header value inside a frame is plain pixel data.
            if (accept && last_pix) state_d = START;
            else if (to_expire)     state_d = IDLE;
         end
         START: begin
            // Done without a visible busy still goes via capture.
            if (fsm_busy || fsm_done) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (fsm_done) state_d = RELEASE;
         end
         RELEASE: begin
            if (!fsm_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         img_we       <= 1'b0;
         img_addr     <= '0;
         img_wdata    <= '0;
         pix_cnt      <= '0;
         start        <= 1'b0;
         result_valid <= 1'b0;
         result_digit <= '0;
         frame_err    <= 1'b0;
      end else begin
         img_we       <= 1'b0;
         result_valid <= 1'b0;
         frame_err    <= 1'b0;
         // Registered start: rises the cycle after the last pixel write,
         // falls the cycle after the result is captured.
         start <= (state_q == START) || (state_q == WAIT_DONE);
         if (in_recv && accept) begin
            img_we    <= 1'b1;
            img_addr  <= pix_cnt;
            img_wdata <= rx_data;
            pix_cnt   <= last_pix ? '0 : pix_cnt + 1'b1;
         end else if (to_expire) begin
            frame_err <= 1'b1;
            pix_cnt   <= '0;
         end
         if ((state_q == WAIT_DONE) && fsm_done) begin
            result_digit <= pred_in;
            result_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_img_frame_loader.sv
// Randomized bench for img_frame_loader: frames, handshake, back-pressure,
// timeout and async reset checked against a frame/result reference model.
module tb_img_frame_loader;

   import mnist_pkg::*;

   localparam int NP = 784;
   localparam int TO = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic       img_we;
   logic [9:0] img_addr;
   logic [7:0] img_wdata;
   logic       start;
   logic       fsm_busy;
   logic       fsm_done;
   logic [3:0] pred_in;
   logic       result_valid;
   logic [3:0] result_digit;
   logic       frame_err;
   logic       loading;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] px [NP];
   logic [9:0] wa_q [$];
   logic [7:0] wd_q [$];
   int         rv_cnt = 0;
   int         fe_cnt = 0;
   int         start_cyc = 0;
   int         exp_rv = 0;
   logic [3:0] exp_digit = '0;

   int         busy_dly = 2;
   int         done_dly = 10;
   int         hold_dly = 0;
   bit         skip_busy = 1'b0;
   logic [3:0] pred_val = '0;

   always #5 clk = ~clk;

   img_frame_loader #(
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .img_we       (img_we),
      .img_addr     (img_addr),
      .img_wdata    (img_wdata),
      .start        (start),
      .fsm_busy     (fsm_busy),
      .fsm_done     (fsm_done),
      .pred_in      (pred_in),
      .result_valid (result_valid),
      .result_digit (result_digit),
      .frame_err    (frame_err),
      .loading      (loading)
   );

   // Observed image buffer writes and event counts.
   always @(negedge clk) begin
      if (rst_n) begin
         if (img_we) begin
            wa_q.push_back(img_addr);
            wd_q.push_back(img_wdata);
         end
         if (result_valid) rv_cnt++;
         if (frame_err) fe_cnt++;
         if (start) start_cyc++;
      end
   end

   // Inference controller model: busy after busy_dly cycles of start,
   // done (level) after a further done_dly; done held until start drops
   // plus hold_dly cycles.
   initial begin
      int c;
      int h;
      c = 0;
      h = 0;
      fsm_busy = 1'b0;
      fsm_done = 1'b0;
      pred_in = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            fsm_busy = 1'b0;
            fsm_done = 1'b0;
            c = 0;
            h = 0;
         end else if (fsm_done) begin
            if (!start) begin
               if (h >= hold_dly) begin
                  fsm_done = 1'b0;
                  c = 0;
                  h = 0;
               end else begin
                  h++;
               end
            end
         end else if (start) begin
            c++;
            if (!skip_busy && c == busy_dly) fsm_busy = 1'b1;
            if (c == busy_dly + done_dly) begin
               fsm_busy = 1'b0;
               fsm_done = 1'b1;
               pred_in = pred_val;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_rx_ready"}, 32'(rx_ready), 0);
      chk({t, "_img_we"}, 32'(img_we), 0);
      chk({t, "_img_addr"}, 32'(img_addr), 0);
      chk({t, "_img_wdata"}, 32'(img_wdata), 0);
      chk({t, "_start"}, 32'(start), 0);
      chk({t, "_result_valid"}, 32'(result_valid), 0);
      chk({t, "_result_digit"}, 32'(result_digit), 0);
      chk({t, "_frame_err"}, 32'(frame_err), 0);
      chk({t, "_loading"}, 32'(loading), 0);
   endtask

   // Offer one byte until accepted; returns 1 ns after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      rx_data = b;
      rx_valid = 1'b1;
      while (!acc && n < 3000) begin
         @(negedge clk);
         acc = rx_ready;
         @(posedge clk);
         #1;
         n++;
      end
      rx_valid = 1'b0;
      if (!acc) chk("rx_accept_timeout", 0, 1);
   endtask

   task automatic send_pixels(input int n, input bit rnd);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
         end
         px[k] = rnd ? 8'($urandom) : 8'(k);
         send_byte(px[k]);
      end
   endtask

   // Pixel k must land at address k with the k-th sent byte.
   task automatic compare_frame(input int n);
      chk("wr_count", wa_q.size(), n);
      for (int k = 0; k < n && k < wa_q.size(); k++) begin
         chk("wr_addr", 32'(wa_q[k]), k);
         chk("wr_data", 32'(wd_q[k]), 32'(px[k]));
      end
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic frame_end();
      @(negedge clk);
      chk("last_we", 32'(img_we), 1);
      chk("last_addr", 32'(img_addr), NP - 1);
      chk("last_start", 32'(start), 0);
      chk("last_rdy", 32'(rx_ready), 0);
      @(negedge clk);
      chk("start_rise", 32'(start), 1);
      chk("post_we", 32'(img_we), 0);
      compare_frame(NP);
   endtask

   task automatic watch_infer(input logic [3:0] pv);
      int n;
      int bad;
      n = 0;
      bad = 0;
      do begin
         @(negedge clk);
         n++;
         if (!result_valid && (rx_ready || img_we)) bad++;
      end while (!result_valid && n < 3000);
      chk("backpressure", bad, 0);
      chk("rv_pulse", 32'(result_valid), 1);
      chk("digit", 32'(result_digit), 32'(pv));
      chk("start_hold", 32'(start), 1);
      @(negedge clk);
      chk("rv_one", 32'(result_valid), 0);
      chk("start_drop", 32'(start), 0);
      chk("rel_rdy", 32'(rx_ready), 0);
      n = 0;
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_rdy", 32'(rx_ready), 1);
      chk("done_fell", 32'(fsm_done), 0);
   endtask

   task automatic set_ctrl(input int bd, input int dd, input int hd,
                           input bit sk, input logic [3:0] pv);
      busy_dly = bd;
      done_dly = dd;
      hold_dly = hd;
      skip_busy = sk;
      pred_val = pv;
   endtask

   // Called at the negedge where start was seen high; with offer set the
   // next header is presented throughout and must only be taken in IDLE.
   task automatic run_infer(input bit offer);
      if (offer) begin
         fork
            send_byte(HDR_BYTE);
            watch_infer(pred_val);
         join
      end else begin
         watch_infer(pred_val);
      end
      exp_rv++;
      exp_digit = pred_val;
      @(negedge clk);
      #1;
      chk("no_wr_after_infer", wa_q.size(), 0);
      sync();
   endtask

   task automatic rand_ctrl(input bit sk);
      set_ctrl(int'($urandom_range(1, 4)), int'($urandom_range(5, 40)),
               int'($urandom_range(0, 3)), sk,
               4'($urandom_range(0, 9)));
   endtask

   initial begin
      int n;
      int sc0;

      #2;
      chk_zero("rst");
      repeat (3) @(negedge clk);
      chk_zero("rst_hold");
      rst_n = 1'b1;
      sync();

      // Preamble garbage, then a k mod 256 frame and the long handshake.
      send_byte(8'h00);
      send_byte(8'h13);
      repeat (3) @(negedge clk);
      chk("pre_no_wr", wa_q.size(), 0);
      chk("pre_idle", 32'(loading), 0);
      sync();
      set_ctrl(2, 900, 3, 1'b0, 4'd7);
      send_byte(HDR_BYTE);
      send_pixels(NP, 1'b0);
      frame_end();
      run_infer(1'b1);

      // Random frames; one controller skips the visible busy pulse.
      rand_ctrl(1'b1);
      send_pixels(NP, 1'b1);
      frame_end();
      run_infer(1'b1);
      rand_ctrl(1'b0);
      send_pixels(NP, 1'b1);
      frame_end();
      run_infer(1'b1);

      // Timeout after 100 pixels.
      sc0 = start_cyc;
      send_pixels(100, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_err && n < 200);
      chk("to_idle_cycles", n - 1, TO);
      @(negedge clk);
      chk("fe_one", 32'(frame_err), 0);
      chk("to_loading", 32'(loading), 0);
      chk("to_rdy", 32'(rx_ready), 1);
      chk("to_no_start", start_cyc - sc0, 0);
      chk("digit_hold", 32'(result_digit), 32'(exp_digit));
      compare_frame(100);
      sync();

      rand_ctrl(1'b0);
      send_byte(HDR_BYTE);
      send_pixels(NP, 1'b1);
      frame_end();
      run_infer(1'b1);

      // Async reset mid-RECV (after pixel 400).
      send_pixels(400, 1'b1);
      rst_n = 1'b0;
      #2;
      chk_zero("rst_recv");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wa_q.delete();
      wd_q.delete();
      exp_digit = '0;
      sync();

      set_ctrl(3, 500, 0, 1'b0, 4'd9);
      send_byte(HDR_BYTE);
      send_pixels(NP, 1'b1);
      frame_end();
      sync();
      n = 0;
      while (!fsm_busy && n < 100) begin
         sync();
         n++;
      end
      repeat (10) sync();
      chk("wait_start", 32'(start), 1);
      chk("wait_rdy", 32'(rx_ready), 0);
      rst_n = 1'b0;
      #2;
      chk_zero("rst_wait");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wa_q.delete();
      wd_q.delete();
      sync();

      rand_ctrl(1'b0);
      send_byte(HDR_BYTE);
      send_pixels(NP, 1'b1);
      frame_end();
      run_infer(1'b0);

      chk("rv_count", rv_cnt, exp_rv);
      chk("fe_count", fe_cnt, 1);
      chk("final_digit", 32'(result_digit), 32'(exp_digit));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/img_frame_loader.md
Name: img_frame_loader

Overview:
- Upstream feeder for the inference controller.
- Accepts a framed byte stream (UART RX side): one header byte, then N_PIX pixel bytes. Writes the pixels into the image buffer.
- Then runs the start/done handshake with the inference controller and latches the predicted digit.
- Sits between the UART receiver and the controller/image-buffer pair on the Basys3 top.

Parameters:
- N_PIX, 784, pixels per frame
- ADDR_W, 10, image buffer address width
- PIX_W, 8, pixel/byte width
- HDR_BYTE, 8'hA5, frame header value
- TIMEOUT_CYC, 1000000, max idle cycles between bytes inside a frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  PIX_W  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready
- img_we  out  1  image buffer write enable
- img_addr  out  ADDR_W  image buffer write address
- img_wdata  out  PIX_W  image buffer write data
- start  out  1  level start to inference controller
- fsm_busy  in  1  controller busy
- fsm_done  in  1  controller done (level, held until start drops)
- pred_in  in  4  controller argmax result
- result_valid  out  1  one-cycle pulse: result_digit updated
- result_digit  out  4  last predicted digit
- frame_err  out  1  one-cycle pulse: frame aborted on timeout
- loading  out  1  high in RECV

Behaviour:
- Reset (async, rst_n low): state=IDLE. Outputs: rx_ready=0, img_we=0, img_addr=0, img_wdata=0, start=0, result_valid=0, result_digit=0, frame_err=0, loading=0. Pixel counter and timeout counter cleared. Reset mid-frame or mid-inference drops start immediately; the partial frame is discarded.
- States and transitions:
  - IDLE: rx_ready=1. An accepted byte equal to HDR_BYTE goes to RECV. Any other byte is discarded and the state stays IDLE.
  - RECV: rx_ready=1, loading=1. Each accepted byte produces a registered write on the next cycle: img_we=1, img_addr=pix_cnt, img_wdata=byte. Then pix_cnt increments. The byte accepted with pix_cnt==N_PIX-1 is written and the state goes to START. A byte equal to HDR_BYTE inside RECV is pixel data, not resync.
  - START: rx_ready=0, start=1. Goes to WAIT_DONE when fsm_busy=1.
  - WAIT_DONE: start held at 1, rx_ready=0. On fsm_done=1: latch result_digit<=pred_in, pulse result_valid for one cycle, go to RELEASE.
  - RELEASE: start=0. Stays until fsm_done=0, then goes to IDLE.
- Image write latency: write appears one cycle after the handshake. No back-to-back hazard, since one byte per cycle maximum. After reset, img_addr for frame pixel k is exactly k, 0..N_PIX-1.
- Timeout: a counter increments every RECV cycle without an accepted byte and clears on each accepted byte. If it reaches TIMEOUT_CYC-1: frame_err pulses one cycle, pix_cnt<=0, state goes to IDLE. The buffer may hold partial data; start is never raised for that frame.
- rx_ready is combinational from state (IDLE/RECV only). Bytes offered in START/WAIT_DONE/RELEASE are back-pressured, not dropped.
- result_digit holds until the next completed inference.
- fsm_done seen while in START (busy pulse missed) is treated as busy+done: the state goes directly through the WAIT_DONE capture.

Decomposition:
- Shared package mnist_pkg: N_PIX, PIX_W, ADDR_W, HDR_BYTE, and the loader state encoding localparams (IDLE=0, RECV=1, START=2, WAIT_DONE=3, RELEASE=4).
- One natural sub-module: byte_timeout_cnt. It is a loadable down-counter with a clear-on-byte input and an expiry pulse output.
- Write datapath and handshake FSM stay in the top module.

Test Plan:
- Full frame: send 0xA5, then 784 bytes with byte k = k mod 256 -> 784 writes, img_addr 0..783, img_wdata = addr[7:0]; start rises one cycle after the last write; no frame_err.
- Preamble garbage: send 0x00, 0x13, 0xA5, then a frame -> first two bytes ignored, no img_we before the header, frame loads normally.
- Handshake: controller model asserts busy 2 cycles after start, done 900 cycles later with pred_in=7 -> result_valid single pulse, result_digit=7; start drops the following cycle; state returns to IDLE only after done falls.
- Back-pressure: offer bytes continuously during WAIT_DONE -> rx_ready=0, no img_we; first byte after return to IDLE is accepted (header).
- Timeout (TIMEOUT_CYC=50 in bench): send header + 100 pixels, stall 60 cycles -> frame_err pulse after 50 idle cycles, start never asserted; next full frame restarts at img_addr=0.
- Async reset: drop rst_n mid-RECV (pixel 400) and mid-WAIT_DONE -> all outputs zero without a clock edge; after release, a fresh frame loads from addr 0.
